plate_frame_loader: RTL
=======================

# plate_frame_loader

Sequential front end that assembles a six-character licence-plate frame from a serial character stream and presents it, with the current day of week, to the plate-validation / barrier-decision logic. Each character is a 4-bit code: 0–9 are digits, 10–15 are letters. The block tracks the day of week (1 = Monday … 7 = Sunday). It holds each completed frame stable under a valid/ack handshake until the decision logic consumes it.

## Interface
- `TIMEOUT`, default 1000: idle cycles allowed between characters while a frame is partially collected.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `char_in` input 4: plate character code, 0–15.
- `char_valid` input 1: `char_in` is valid this cycle.
- `char_ready` output 1: block can accept a character this cycle.
- `day_tick` input 1: single-cycle pulse that advances the day of week.
- `A`, `B`, `C`, `D`, `E`, `F` output 4 each: frame characters 1–6, in arrival order.
- `Dia` output 3: day of week captured with the frame, 3'b001–3'b111.
- `plate_valid` output 1: frame on `A`–`F` / `Dia` is complete and stable.
- `plate_ack` input 1: consumer has taken the frame.
- `frame_drop` output 1: one-cycle pulse when a partial frame is abandoned.
- `fmt_ok` output 1: format flag for the presented frame (see Configuration).

## Operation
- States:
  - `IDLE`: no characters held.
  - `COLLECT`: 1–5 characters held.
  - `PRESENT`: frame complete.
- Character acceptance:
  - A character is accepted on any cycle where `char_valid && char_ready`.
  - `char_ready` = 1 in `IDLE` and `COLLECT`, 0 in `PRESENT`.
  - Accepted characters load `A`, `B`, `C`, `D`, `E`, `F` in order, using a 3-bit index 0..5.
- Transitions:
  - `IDLE` → `COLLECT` on the first accepted character.
  - `COLLECT` → `PRESENT` on the sixth accepted character. On that same edge, the current day register is copied to `Dia`.
  - `PRESENT` → `IDLE` on `plate_ack`. The index clears; `A`–`F` keep their values.
- `plate_ack` outside `PRESENT` is ignored.
- Timeout:
  - An idle counter runs only in `COLLECT`. It clears on every accepted character.
  - When it reaches `TIMEOUT` cycles with no acceptance, the state returns to `IDLE`, the index clears, and `frame_drop` pulses for 1 cycle.
  - The counter width is `$clog2(TIMEOUT+1)`.
- Day counter:
  - Internal, 3 bits, range 1..7.
  - Increments on `day_tick`; 7 wraps to 1.
  - Runs in every state.
  - `day_tick` on the capture edge: `Dia` takes the pre-increment value.
- `Dia` changes only on a capture edge, never while `plate_valid` = 1.

## Timing
- Reset values:
  - State `IDLE`, index 0.
  - `A`–`F` = 0.
  - Internal day = 3'b001, `Dia` = 3'b001.
  - `plate_valid` = 0, `frame_drop` = 0, idle counter 0.
  - `char_ready` = 1.
  - `fmt_ok` = 0 with the macro defined, 1 without.
- Latency:
  - `plate_valid` rises the cycle after the edge that accepts the sixth character.
  - `char_ready` falls in that same cycle.
- Handshake:
  - `plate_valid` stays 1 and `A`–`F` / `Dia` stay stable until `plate_ack` is sampled high.
  - `plate_valid` is 0 the following cycle and `char_ready` is 1.
  - The next character can be accepted in the cycle after the ack, so the minimum frame-to-frame spacing is 7 cycles.
- Simultaneous events:
  - `char_valid` together with a timeout expiry: the character wins. It is accepted, the counter clears, and there is no drop.
  - `char_valid` while in `PRESENT` is not accepted (`char_ready` = 0).
- Reset mid-operation: any partial or presented frame is discarded immediately and all outputs go to their reset values asynchronously.
- All outputs are registered. There is no combinational path from inputs to outputs except to `char_ready`, which is a decode of the state register only.

## Configuration
- `PLATE_FORMAT_CHECK_EN` defined:
  - `fmt_ok` is registered on the capture edge and is valid while `plate_valid` = 1.
  - `fmt_ok` = 1 only if pairs (A,B), (C,D) and (E,F) are each homogeneous (both ≤ 9, or both > 9) and not all six characters are letters.
  - `fmt_ok` is cleared when `plate_ack` is accepted.
- Not defined: no check logic is built and `fmt_ok` is tied to 1.

## Test plan
- After reset, feed 1,2,10,11,3,4 on consecutive cycles:
  - `plate_valid` = 1 on cycle 7.
  - `A`–`F` = 1,2,A,B,3,4, `Dia` = 1, `char_ready` = 0.
  - `fmt_ok` = 1 (with macro).
- Present a frame, hold `plate_ack` = 0 for 20 cycles and toggle `char_valid`:
  - Outputs stay stable, no character is accepted.
  - Assert ack → `plate_valid` = 0 next cycle, `char_ready` = 1.
- Send 8 `day_tick` pulses, then a frame:
  - `Dia` = 3'b010 (1 → 7 → 1 → 2 wrap).
  - A `day_tick` coincident with the sixth character yields the pre-increment `Dia`.
- With `TIMEOUT`=10, feed 3 characters then idle:
  - `frame_drop` pulses once after 10 idle cycles and the state is `IDLE`.
  - The next 6 characters form a fresh frame starting at `A`.
- With the macro defined:
  - Frame 1,10,2,3,4,5 → `fmt_ok` = 0.
  - Frame 10,11,12,13,14,15 → `fmt_ok` = 0.
- Assert `rst` after 4 characters and again during `PRESENT`:
  - All outputs return to reset values immediately.
  - The first character after release loads `A`.

Source files
------------

// File: rtl/plate_frame_loader_if.sv
// -----------------------------------------------------------------------------
// plate_frame_loader_if
//
// Bundle of the character-stream, day-tick and frame-presentation signals
// exchanged between the plate frame loader and its neighbours.
//
//   slave  modport : the loader itself (accepts characters, presents frames)
//   master modport : the environment (character source + decision logic)
//
// Signals
//   char_in[3:0]  character code, 0-9 digits, 10-15 letters
//   char_valid    char_in valid this cycle
//   char_ready    loader can accept a character this cycle
//   day_tick      one-cycle pulse advancing the day of week
//   A..F[3:0]     frame characters 1..6 in arrival order
//   Dia[2:0]      day of week captured with the frame (1..7)
//   plate_valid   frame on A..F / Dia complete and stable
//   plate_ack     consumer has taken the frame
//   frame_drop    one-cycle pulse when a partial frame is abandoned
//   fmt_ok        format flag for the presented frame
// -----------------------------------------------------------------------------
interface plate_frame_loader_if;
    logic [3:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       day_tick;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic [3:0] D;
    logic [3:0] E;
    logic [3:0] F;
    logic [2:0] Dia;
    logic       plate_valid;
    logic       plate_ack;
    logic       frame_drop;
    logic       fmt_ok;

    modport slave (
        input  char_in, char_valid, day_tick, plate_ack,
        output char_ready, A, B, C, D, E, F, Dia, plate_valid, frame_drop, fmt_ok
    );

    modport master (
        output char_in, char_valid, day_tick, plate_ack,
        input  char_ready, A, B, C, D, E, F, Dia, plate_valid, frame_drop, fmt_ok
    );
endinterface

// File: rtl/plate_frame_loader.sv
// -----------------------------------------------------------------------------
// plate_frame_loader
//
// Assembles a six-character licence-plate frame from a serial 4-bit character
// stream and presents it, together with the current day of week, under a
// valid/ack handshake. A partial frame that sits idle for TIMEOUT cycles is
// abandoned with a one-cycle frame_drop pulse.
//
// Parameters
//   TIMEOUT  idle cycles allowed between characters of a partial frame
//
// Ports
//   clk   single clock, rising edge
//   rst   asynchronous active-high reset
//   bus   plate_frame_loader_if.slave (character stream, day tick,
//         frame outputs and handshake; see the interface file)
//
// Optional feature
//   PLATE_FORMAT_CHECK_EN  when defined, fmt_ok is computed on the capture
//                          edge; otherwise fmt_ok is tied to 1.
// -----------------------------------------------------------------------------
module plate_frame_loader #(
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    plate_frame_loader_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          idx_q,   idx_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [5:0][3:0]     chr_q,   chr_d;
    logic [2:0]          day_q,   day_d;
    logic [2:0]          dia_q,   dia_d;
    logic                pv_q,    pv_d;
    logic                drop_q,  drop_d;

    logic                accept;
    logic                expire;

`ifdef PLATE_FORMAT_CHECK_EN
    logic                fmt_q,   fmt_d;

    function automatic logic is_letter(input logic [3:0] c);
        return (c > 4'd9);
    endfunction

    // Each pair must be homogeneous and the plate must not be all letters.
    function automatic logic fmt_check(input logic [5:0][3:0] f);
        logic pairs_ok;
        logic all_letters;
        pairs_ok    = (is_letter(f[0]) == is_letter(f[1])) &&
                      (is_letter(f[2]) == is_letter(f[3])) &&
                      (is_letter(f[4]) == is_letter(f[5]));
        all_letters = is_letter(f[0]) && is_letter(f[1]) && is_letter(f[2]) &&
                      is_letter(f[3]) && is_letter(f[4]) && is_letter(f[5]);
        return pairs_ok && !all_letters;
    endfunction
`endif

    // A character arriving on the expiry cycle is accepted, so expiry is
    // qualified with !accept.
    assign accept = bus.char_valid && (state_q != PRESENT);
    assign expire = (state_q == COLLECT) && !accept &&
                    (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        chr_d   = chr_q;
        dia_d   = dia_q;
        pv_d    = pv_q;
        drop_d  = 1'b0;
`ifdef PLATE_FORMAT_CHECK_EN
        fmt_d   = fmt_q;
`endif

        // Day counter runs in every state, 7 wraps to 1.
        day_d = day_q;
        if (bus.day_tick) begin
            day_d = (day_q == 3'd7) ? 3'd1 : day_q + 3'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    chr_d[idx_q] = bus.char_in;
                    idx_d        = idx_q + 3'd1;
                    cnt_d        = '0;
                    state_d      = COLLECT;
                end
            end

            COLLECT: begin
                if (accept) begin
                    chr_d[idx_q] = bus.char_in;
                    cnt_d        = '0;
                    if (idx_q == 3'd5) begin
                        // Capture edge: Dia takes the pre-increment day.
                        state_d = PRESENT;
                        pv_d    = 1'b1;
                        dia_d   = day_q;
`ifdef PLATE_FORMAT_CHECK_EN
                        fmt_d   = fmt_check(chr_d);
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else if (expire) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    cnt_d   = '0;
                    drop_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESENT: begin
                // A..F keep their values after the ack; only the index clears.
                if (bus.plate_ack) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                    pv_d    = 1'b0;
`ifdef PLATE_FORMAT_CHECK_EN
                    fmt_d   = 1'b0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
                cnt_d   = '0;
                pv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            chr_q   <= '0;
            day_q   <= 3'd1;
            dia_q   <= 3'd1;
            pv_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            chr_q   <= chr_d;
            day_q   <= day_d;
            dia_q   <= dia_d;
            pv_q    <= pv_d;
            drop_q  <= drop_d;
        end
    end

`ifdef PLATE_FORMAT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fmt_q <= 1'b0;
        end else begin
            fmt_q <= fmt_d;
        end
    end

    assign bus.fmt_ok = fmt_q;
`else
    assign bus.fmt_ok = 1'b1;
`endif

    // char_ready is a pure decode of the state register.
    assign bus.char_ready  = (state_q != PRESENT);
    assign bus.A           = chr_q[0];
    assign bus.B           = chr_q[1];
    assign bus.C           = chr_q[2];
    assign bus.D           = chr_q[3];
    assign bus.E           = chr_q[4];
    assign bus.F           = chr_q[5];
    assign bus.Dia         = dia_q;
    assign bus.plate_valid = pv_q;
    assign bus.frame_drop  = drop_q;

endmodule
